// File: rtl/dsp_mac_sequencer_if.sv
// Operand stream, result stream and DSP48E2 wrapper ports of dsp_mac_sequencer.
// res_len exists only when DSP_MAC_LEN_EN is defined.
`timescale 1ns/1ps
interface dsp_mac_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] in_a;
  logic [17:0] in_b;
  logic        in_last;
  logic        dsp_enable;
  logic [29:0] dsp_a;
  logic [17:0] dsp_b;
  logic [47:0] dsp_c;
  logic [26:0] dsp_d;
  logic [8:0]  dsp_opmode;
  logic [4:0]  dsp_inmode;
  logic [3:0]  dsp_alumode;
  logic [47:0] dsp_p;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_data;
`ifdef DSP_MAC_LEN_EN
  logic [15:0] res_len;
`endif

  modport master (
    output in_valid, in_a, in_b, in_last,
    output res_ready, dsp_p,
    input  in_ready, dsp_enable, dsp_a, dsp_b,
    input  dsp_c, dsp_d, dsp_opmode,
    input  dsp_inmode, dsp_alumode,
`ifdef DSP_MAC_LEN_EN
    input  res_len,
`endif
    input  res_valid, res_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last,
    input  res_ready, dsp_p,
    output in_ready, dsp_enable, dsp_a, dsp_b,
    output dsp_c, dsp_d, dsp_opmode,
    output dsp_inmode, dsp_alumode,
`ifdef DSP_MAC_LEN_EN
    output res_len,
`endif
    output res_valid, res_data
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Drives a DSP48E2 wrapper to reduce (a,b,last) beats to signed dot products.
// Optional DSP_MAC_LEN_EN adds res_len (saturating element count per vector).
`timescale 1ns/1ps
module dsp_mac_sequencer #(
  parameter int INPUTREG   = 1,
  parameter int DSPPIPEREG = 1,
  parameter int OUTPUTREG  = 1,
  parameter int CONTROLREG = 1
) (
  input logic clk,
  input logic rst,
  dsp_mac_sequencer_if.slave bus
);
  localparam int LAT   = INPUTREG + DSPPIPEREG + OUTPUTREG;
  localparam int SKEW  = INPUTREG + DSPPIPEREG - CONTROLREG;
  localparam int LAT_W = (LAT > 0) ? LAT : 1;
  localparam int SKW_W = (SKEW > 0) ? SKEW : 1;

  localparam logic [8:0] OP_M    = 9'h005;
  localparam logic [8:0] OP_PM   = 9'h025;
  localparam logic [8:0] OP_HOLD = 9'h020;

  generate
    if (SKEW < 0) begin : g_skew_err
      $error("CONTROLREG exceeds INPUTREG+DSPPIPEREG");
    end
  endgenerate

  typedef enum logic {ST_FIRST = 1'b0, ST_ACCUM = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             stall, en, acc, tag_in, tag_out, cap;
  logic [8:0]       op_slot;
  logic [8:0]       op_q [SKW_W];
  logic [8:0]       op_d [SKW_W];
  logic [LAT_W-1:0] tag_q, tag_d;
  logic             res_valid_q, res_valid_d;
  logic [47:0]      res_data_q, res_data_d;

  // Stall whenever a result sits unaccepted, in flight or not.
  assign stall  = res_valid_q & ~bus.res_ready;
  assign en     = ~stall;
  assign acc    = bus.in_valid & en & ~rst;
  assign tag_in = acc & bus.in_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FIRST;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (acc) state_d = bus.in_last ? ST_FIRST : ST_ACCUM;
  end

  always_comb begin
    op_slot = OP_HOLD;
    if (acc) begin
      unique case (state_q)
        ST_FIRST: op_slot = OP_M;
        ST_ACCUM: op_slot = OP_PM;
        default:  op_slot = OP_HOLD;
      endcase
    end
  end

  always_comb begin
    op_d  = op_q;
    tag_d = tag_q;
    if (en) begin
      op_d[0]  = op_slot;
      tag_d[0] = tag_in;
      for (int i = 1; i < SKW_W; i++) op_d[i] = op_q[i-1];
      for (int i = 1; i < LAT_W; i++) tag_d[i] = tag_q[i-1];
    end
  end

  assign tag_out = (LAT == 0) ? tag_in : tag_q[LAT_W-1];
  assign cap     = tag_out & en;

  // A new capture on the same edge as a consume keeps res_valid high.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (res_valid_q & bus.res_ready) res_valid_d = 1'b0;
    if (cap) begin
      res_valid_d = 1'b1;
      res_data_d  = bus.dsp_p;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      for (int i = 0; i < SKW_W; i++) op_q[i] <= OP_HOLD;
    end else begin
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      op_q        <= op_d;
    end
  end

`ifdef DSP_MAC_LEN_EN
  logic [15:0] cnt_q, cnt_d, cur_len, len_out;
  logic [15:0] res_len_q, res_len_d;
  logic [15:0] len_q [LAT_W];
  logic [15:0] len_d [LAT_W];

  always_comb begin
    cur_len = 16'd1;
    if (state_q == ST_ACCUM)
      cur_len = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    cnt_d = acc ? cur_len : cnt_q;
    len_d = len_q;
    if (en) begin
      len_d[0] = tag_in ? cur_len : 16'd0;
      for (int i = 1; i < LAT_W; i++) len_d[i] = len_q[i-1];
    end
  end

  assign len_out   = (LAT == 0) ? cur_len : len_q[LAT_W-1];
  assign res_len_d = cap ? len_out : res_len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      res_len_q <= '0;
      for (int i = 0; i < LAT_W; i++) len_q[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      res_len_q <= res_len_d;
      len_q     <= len_d;
    end
  end

  assign bus.res_len = res_len_q;
`endif

  assign bus.in_ready    = en;
  assign bus.dsp_enable  = en;
  assign bus.dsp_a       = acc ? {{3{bus.in_a[26]}}, bus.in_a} : 30'd0;
  assign bus.dsp_b       = acc ? bus.in_b : 18'd0;
  assign bus.dsp_c       = 48'd0;
  assign bus.dsp_d       = 27'd0;
  assign bus.dsp_opmode  = (SKEW <= 0) ? op_slot : op_q[SKW_W-1];
  assign bus.dsp_inmode  = 5'b00000;
  assign bus.dsp_alumode = 4'b0000;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48E2 (A/B, M, P, OPMODE regs).
// Results are compared against dot products computed from the stimulus.
`timescale 1ns/1ps
module tb_dsp_mac_sequencer;
  logic clk, rst;
  int   n_chk, n_fail;

  dsp_mac_sequencer_if bus();
  dsp_mac_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wrapper model: A/B reg, M reg, P reg, OPMODE reg, all on CE.
  logic [29:0] ma_r;
  logic [17:0] mb_r;
  logic [47:0] mm_r, mp_r;
  logic [8:0]  mop_r;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma_r <= '0; mb_r <= '0; mm_r <= '0; mp_r <= '0; mop_r <= '0;
    end else if (bus.dsp_enable) begin
      ma_r  <= bus.dsp_a;
      mb_r  <= bus.dsp_b;
      mm_r  <= 48'(longint'($signed(ma_r[26:0])) * longint'($signed(mb_r)));
      mop_r <= bus.dsp_opmode;
      mp_r  <= ((mop_r[3:0] == 4'b0101) ? mm_r : 48'd0)
             + ((mop_r[6:4] == 3'b010) ? mp_r : 48'd0);
    end
  end
  assign bus.dsp_p = mp_r;

  logic [47:0] got_q[$];
  logic [15:0] got_len_q[$];
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      got_q.push_back(bus.res_data);
`ifdef DSP_MAC_LEN_EN
      got_len_q.push_back(bus.res_len);
`endif
    end
  end

  function automatic logic [47:0] dot(input logic [26:0] a[$], input logic [17:0] b[$]);
    longint s = 0;
    foreach (a[i]) s += longint'($signed(a[i])) * longint'($signed(b[i]));
    return 48'(s);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [26:0] a, input logic [17:0] b,
                           input logic last, input int gap);
    bit took = 0;
    int w = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_last = last;
    while (!took && w < 500) begin
      @(negedge clk); took = bus.in_ready;
      tick(); w++;
    end
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0;
    n_chk++;
    if (!took) begin
      n_fail++;
      $display("FAIL beat_accept: in_ready low for %0d cycles, required 1", w);
    end
    repeat (gap) tick();
  endtask

  task automatic wait_results(input int n);
    int w = 0;
    while (got_q.size() < n && w < 2000) begin tick(); w++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 0;
    bus.res_ready = 1'b1;
    repeat (3) tick();
    n_chk += 7;
    if (bus.res_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_res_valid: got %b, required 0", bus.res_valid); end
    if (bus.res_data !== 48'd0) begin n_fail++;
      $display("FAIL rst_res_data: got %h, required 0", bus.res_data); end
    if (bus.dsp_enable !== 1'b1) begin n_fail++;
      $display("FAIL rst_enable: got %b, required 1", bus.dsp_enable); end
    if (bus.dsp_opmode !== 9'h020) begin n_fail++;
      $display("FAIL rst_opmode: got %h, required 020", bus.dsp_opmode); end
    if (bus.dsp_a !== 30'd0 || bus.dsp_b !== 18'd0) begin n_fail++;
      $display("FAIL rst_ab: got %h/%h, required 0/0", bus.dsp_a, bus.dsp_b); end
    if (bus.dsp_c !== 48'd0 || bus.dsp_d !== 27'd0) begin n_fail++;
      $display("FAIL const_cd: got %h/%h, required 0/0", bus.dsp_c, bus.dsp_d); end
    if (bus.dsp_inmode !== 5'd0 || bus.dsp_alumode !== 4'd0) begin n_fail++;
      $display("FAIL const_modes: got %h/%h, required 0/0",
               bus.dsp_inmode, bus.dsp_alumode); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_dot();
    int n;
    logic [47:0] v;
    got_q.delete(); got_len_q.delete();
    bus.res_ready = 1'b1;
    send_beat(27'd1, 18'd4, 1'b0, 0);
    n_chk++;
    if (bus.dsp_opmode !== 9'h005) begin n_fail++;
      $display("FAIL dot_op_first: got %h, required 005", bus.dsp_opmode); end
    send_beat(27'd2, 18'd5, 1'b0, 0);
    n_chk++;
    if (bus.dsp_opmode !== 9'h025) begin n_fail++;
      $display("FAIL dot_op_accum: got %h, required 025", bus.dsp_opmode); end
    send_beat(27'd3, 18'd6, 1'b1, 0);
    n = 1;
    while (!bus.res_valid && n < 20) begin tick(); n++; end
    n_chk++;
    if (n !== 4) begin n_fail++;
      $display("FAIL dot_latency: got %0d cycles, required 4", n); end
    wait_results(1);
    v = (got_q.size() > 0) ? got_q[0] : 'x;
    n_chk++;
    if (v !== 48'd32) begin n_fail++;
      $display("FAIL dot_value: got %h, required 32", v); end
`ifdef DSP_MAC_LEN_EN
    n_chk++;
    if (got_len_q.size() < 1 || got_len_q[0] !== 16'd3) begin n_fail++;
      $display("FAIL dot_len: got %0d entries, required len 3", got_len_q.size()); end
`endif
  endtask

  task automatic test_single();
    logic [47:0] v0, v1;
    got_q.delete(); got_len_q.delete();
    send_beat(27'h7FFFFFD, 18'd7, 1'b1, 0);
    send_beat(27'd2, 18'd2, 1'b1, 0);
    wait_results(2);
    v0 = (got_q.size() > 0) ? got_q[0] : 'x;
    v1 = (got_q.size() > 1) ? got_q[1] : 'x;
    n_chk += 2;
    if (v0 !== 48'hFFFF_FFFF_FFEB) begin n_fail++;
      $display("FAIL single_neg: got %h, required ffffffffffeb", v0); end
    if (v1 !== 48'd4) begin n_fail++;
      $display("FAIL single_next: got %h, required 4", v1); end
  endtask

  task automatic test_bubbles();
    logic [47:0] v;
    got_q.delete(); got_len_q.delete();
    send_beat(27'd1, 18'd4, 1'b0, 2);
    send_beat(27'd2, 18'd5, 1'b0, 2);
    send_beat(27'd3, 18'd6, 1'b1, 0);
    wait_results(1);
    v = (got_q.size() > 0) ? got_q[0] : 'x;
    n_chk++;
    if (v !== 48'd32) begin n_fail++;
      $display("FAIL bubble_value: got %h, required 32", v); end
  endtask

  task automatic test_back_to_back();
    int w = 0;
    logic [47:0] v0, v1;
    got_q.delete(); got_len_q.delete();
    bus.res_ready = 1'b0;
    send_beat(27'd1, 18'd4, 1'b0, 0);
    send_beat(27'd2, 18'd5, 1'b0, 0);
    send_beat(27'd3, 18'd6, 1'b1, 0);
    send_beat(27'd5, 18'h3FFFB, 1'b1, 0);
    while (!bus.res_valid && w < 50) begin tick(); w++; end
    for (int i = 0; i < 6; i++) begin
      n_chk += 3;
      if (bus.in_ready !== 1'b0) begin n_fail++;
        $display("FAIL bp_in_ready[%0d]: got %b, required 0", i, bus.in_ready); end
      if (bus.dsp_enable !== 1'b0) begin n_fail++;
        $display("FAIL bp_enable[%0d]: got %b, required 0", i, bus.dsp_enable); end
      if (bus.res_data !== 48'd32) begin n_fail++;
        $display("FAIL bp_hold[%0d]: got %h, required 32", i, bus.res_data); end
      tick();
    end
    bus.res_ready = 1'b1;
    wait_results(2);
    repeat (8) tick();
    v0 = (got_q.size() > 0) ? got_q[0] : 'x;
    v1 = (got_q.size() > 1) ? got_q[1] : 'x;
    n_chk += 3;
    if (got_q.size() !== 2) begin n_fail++;
      $display("FAIL bp_count: got %0d results, required 2", got_q.size()); end
    if (v0 !== 48'd32) begin n_fail++;
      $display("FAIL bp_first: got %h, required 32", v0); end
    if (v1 !== 48'hFFFF_FFFF_FFE7) begin n_fail++;
      $display("FAIL bp_second: got %h, required ffffffffffe7", v1); end
  endtask

  task automatic test_wrap();
    logic [47:0] v;
    got_q.delete(); got_len_q.delete();
    for (int i = 0; i < 32; i++)
      send_beat(27'h4000000, 18'h20000, (i == 31), 0);
    wait_results(1);
    v = (got_q.size() > 0) ? got_q[0] : 'x;
    n_chk++;
    if (v !== 48'd0) begin n_fail++;
      $display("FAIL wrap_value: got %h, required 0", v); end
  endtask

  task automatic test_mid_reset();
    int w = 0;
    logic [47:0] v;
    bus.res_ready = 1'b0;
    send_beat(27'd7, 18'd1, 1'b1, 0);
    send_beat(27'd1, 18'd4, 1'b0, 0);
    send_beat(27'd2, 18'd5, 1'b0, 0);
    while (!bus.res_valid && w < 50) begin tick(); w++; end
    n_chk++;
    if (bus.res_valid !== 1'b1) begin n_fail++;
      $display("FAIL mr_pending: got %b, required 1", bus.res_valid); end
    rst = 1'b1;
    #1;
    n_chk += 3;
    if (bus.res_valid !== 1'b0) begin n_fail++;
      $display("FAIL mr_valid: got %b, required 0", bus.res_valid); end
    if (bus.res_data !== 48'd0) begin n_fail++;
      $display("FAIL mr_data: got %h, required 0", bus.res_data); end
    if (bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL mr_ready: got %b, required 1", bus.in_ready); end
    repeat (2) tick();
    rst = 1'b0;
    bus.res_ready = 1'b1;
    got_q.delete(); got_len_q.delete();
    tick();
    send_beat(27'd1, 18'd9, 1'b1, 0);
    n_chk++;
    if (bus.dsp_opmode !== 9'h005) begin n_fail++;
      $display("FAIL mr_op_first: got %h, required 005", bus.dsp_opmode); end
    wait_results(1);
    repeat (6) tick();
    v = (got_q.size() > 0) ? got_q[0] : 'x;
    n_chk += 2;
    if (v !== 48'd9) begin n_fail++;
      $display("FAIL mr_value: got %h, required 9", v); end
    if (got_q.size() !== 1) begin n_fail++;
      $display("FAIL mr_count: got %0d results, required 1", got_q.size()); end
  endtask

  task automatic test_random();
    localparam int NV = 12;
    logic [47:0] exp_q[$];
    int          exp_len[$];
    logic [26:0] va[$];
    logic [17:0] vb[$];
    logic [47:0] v;
    bit drv_done = 0;
    got_q.delete(); got_len_q.delete();
    fork
      begin
        for (int k = 0; k < NV; k++) begin
          int len = $urandom_range(1, 6);
          va.delete(); vb.delete();
          for (int i = 0; i < len; i++) begin
            va.push_back(27'($urandom));
            vb.push_back(18'($urandom));
          end
          exp_q.push_back(dot(va, vb));
          exp_len.push_back(len);
          for (int i = 0; i < len; i++)
            send_beat(va[i], vb[i], (i == len - 1), $urandom_range(0, 2));
        end
        drv_done = 1;
      end
      begin
        int k = 0;
        while (!drv_done && k < 20000) begin
          bus.res_ready = ($urandom_range(0, 3) != 0);
          tick(); k++;
        end
        bus.res_ready = 1'b1;
      end
    join
    wait_results(NV);
    repeat (6) tick();
    n_chk++;
    if (got_q.size() !== NV) begin n_fail++;
      $display("FAIL rnd_count: got %0d results, required %0d", got_q.size(), NV); end
    for (int k = 0; k < NV; k++) begin
      v = (got_q.size() > k) ? got_q[k] : 'x;
      n_chk++;
      if (v !== exp_q[k]) begin n_fail++;
        $display("FAIL rnd_value[%0d]: got %h, required %h", k, v, exp_q[k]); end
`ifdef DSP_MAC_LEN_EN
      n_chk++;
      if (got_len_q.size() <= k || got_len_q[k] !== 16'(exp_len[k])) begin n_fail++;
        $display("FAIL rnd_len[%0d]: required %0d", k, exp_len[k]); end
`endif
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_dot();
    test_single();
    test_bubbles();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
